// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the core port (0) and the
// loader/debug port (1). Each grant runs one access and returns a single-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          sel1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant_d  = grant_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    // On a tie, port 1 wins only if port 0 was served last (last_q == 0).
    sel1     = req1 && !(req0 && last_q);

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d  = sel1 ? 2'b10 : 2'b01;
          last_d   = sel1;
          mem_we_d = sel1 ? we1 : we0;
          addr_d   = sel1 ? addr1 : addr0;
          wdata_d  = sel1 ? wdata1 : wdata0;
          cnt_d    = CntLoad;
          mem_en_d = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          // mem_we_q doubles as the latched direction of the access in flight.
          if (!mem_we_q) begin
            if (grant_q[1]) rdata1_d = mem_rdata;
            else            rdata0_d = mem_rdata;
          end
          ack0_d   = grant_q[0];
          ack1_d   = grant_q[1];
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-schedule model and a word-addressed backing memory.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  // Memory seen by the DUT, and the model's own copy updated at grant time.
  logic [DW-1:0] tbmem [256];
  logic [DW-1:0] mm    [256];
  assign mem_rdata = tbmem[mem_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_we     = 0;

  // Model: one transaction record; its cycle windows derive from the grant cycle.
  bit            m_valid;
  int            m_start;
  int            m_idle_at;
  bit            m_port, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rval;
  logic [DW-1:0] m_rd [2];

  bit rand_mode, rereq_mode;
  int ack_cyc  [$];
  bit ack_port [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_last    = 1'b1;
    m_rd[0]   = '0;
    m_rd[1]   = '0;
    m_idle_at = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      if (m_valid && cyc == m_start + LAT && !m_we) m_rd[m_port] = m_rval;
      if (cyc - 1 >= m_idle_at && (req[0] || req[1])) begin
        m_port    = (req[0] && req[1]) ? !m_last : req[1];
        m_last    = m_port;
        m_we      = we[m_port];
        m_addr    = addr[m_port];
        m_wdata   = wdata[m_port];
        m_rval    = mm[m_addr[9:2]];
        if (m_we) mm[m_addr[9:2]] = m_wdata;
        m_start   = cyc;
        m_idle_at = cyc + LAT + 1;
        m_valid   = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit b, r;
    b = m_valid && cyc >= m_start && cyc < m_start + LAT;
    r = m_valid && cyc == m_start + LAT;
    check("busy",   64'(busy),   64'(b || r));
    check("grant",  64'(grant),  (b || r) ? (m_port ? 64'd2 : 64'd1) : 64'd0);
    check("mem_en", 64'(mem_en), 64'(b));
    check("mem_we", 64'(mem_we), 64'(b && m_we));
    if (b) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check("ack0",   64'(ack0),   64'(r && !m_port));
    check("ack1",   64'(ack1),   64'(r && m_port));
    check("rdata0", 64'(rdata0), 64'(m_rd[0]));
    check("rdata1", 64'(rdata1), 64'(m_rd[1]));
  endtask

  task automatic new_req(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(0, 1));
    addr[p]  = $urandom;
    wdata[p] = $urandom;
  endtask

  task automatic step();
    logic          wen;
    logic [7:0]    wa;
    logic [DW-1:0] wd;
    wen = mem_en && mem_we;
    wa  = mem_addr[9:2];
    wd  = mem_wdata;
    @(posedge clk);
    cyc++;
    if (wen) tbmem[wa] = wd;
    model_edge();
    #1;
    check_outputs();
    if (mem_we) n_we++;
    if (ack0) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b0); end
    if (ack1) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b1); end
    for (int p = 0; p < 2; p++) begin
      bit ack_e, own_busy;
      ack_e    = m_valid && cyc == m_start + LAT && int'(m_port) == p;
      own_busy = m_valid && cyc >= m_start && cyc < m_start + LAT && int'(m_port) == p;
      if (ack_e) begin
        if (rereq_mode) new_req(p);
        else begin
          req[p] = 1'b0;
          if (rand_mode && $urandom_range(0, 1) == 1) new_req(p);
        end
      end else if (rand_mode) begin
        if (!req[p] && $urandom_range(0, 3) == 0) new_req(p);
        else if (own_busy && $urandom_range(0, 3) == 0) begin
          // Disturb inputs of the access in flight; they must be ignored.
          we[p]    = ~we[p];
          addr[p]  = $urandom;
          wdata[p] = $urandom;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = $urandom;
      mm[i]    = tbmem[i];
    end
    rst = 1'b0;
    req = 2'b00;
    we  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
    end
    rand_mode  = 1'b0;
    rereq_mode = 1'b0;
    model_reset();

    // Reset then idle
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    check("idle_mem_addr",  64'(mem_addr),  64'd0);
    check("idle_mem_wdata", 64'(mem_wdata), 64'd0);

    // Single read on port 0
    tbmem[16] = 32'h1234_5678;
    mm[16]    = 32'h1234_5678;
    ack_cyc.delete(); ack_port.delete();
    begin
      int t0;
      t0 = cyc;
      addr[0] = 32'h40; we[0] = 1'b0; req[0] = 1'b1;
      repeat (6) step();
      check("rd_ack_count", 64'(ack_cyc.size()), 64'd1);
      if (ack_cyc.size() > 0) begin
        check("rd_ack_latency", 64'(ack_cyc[0] - t0), 64'(LAT + 1));
        check("rd_ack_port",    64'(ack_port[0]),     64'd0);
      end
      check("rd_data", 64'(rdata0), 64'h1234_5678);
    end

    // Single write on port 1
    ack_cyc.delete(); ack_port.delete();
    n_we = 0;
    addr[1] = 32'h100; wdata[1] = 32'hDEAD_BEEF; we[1] = 1'b1; req[1] = 1'b1;
    repeat (6) step();
    check("wr_we_cycles", 64'(n_we), 64'(LAT));
    check("wr_ack_count", 64'(ack_cyc.size()), 64'd1);
    check("wr_mem",       64'(tbmem[64]), 64'hDEAD_BEEF);
    check("wr_rdata1",    64'(rdata1), 64'd0);

    // Contention: both ports hold and re-request after every ack
    ack_cyc.delete(); ack_port.delete();
    rereq_mode = 1'b1;
    new_req(0);
    new_req(1);
    repeat (4 * (LAT + 2) + 2) step();
    rereq_mode = 1'b0;
    req = 2'b00;
    repeat (LAT + 3) step();
    check("cont_ack_count", 64'(ack_cyc.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      check("cont_ack_order", 64'(ack_port[i]), 64'(i % 2));
      if (i > 0) check("cont_ack_gap", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(LAT + 2));
    end

    // Inputs change while the access is in flight
    addr[0] = 32'h40; we[0] = 1'b0; req[0] = 1'b1;
    step();
    check("chg_addr_first", 64'(mem_addr), 64'h40);
    addr[0] = 32'h80; we[0] = 1'b1; wdata[0] = 32'hCAFE_F00D;
    step();
    check("chg_addr_last", 64'(mem_addr), 64'h40);
    check("chg_we_last",   64'(mem_we),   64'd0);
    repeat (LAT + 2) step();
    check("chg_rdata", 64'(rdata0), 64'(mm[16]));

    // Reset in the second BUSY cycle
    ack_cyc.delete(); ack_port.delete();
    addr[0] = 32'h44; we[0] = 1'b0; req[0] = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mem_en", 64'(mem_en), 64'd0);
    check("mid_rst_grant",  64'(grant),  64'd0);
    check("mid_rst_busy",   64'(busy),   64'd0);
    check("mid_rst_rdata0", 64'(rdata0), 64'd0);
    model_reset();
    req = 2'b00;
    repeat (2) step();
    check("mid_rst_no_ack", 64'(ack_cyc.size()), 64'd0);
    rst = 1'b1;
    new_req(0);
    new_req(1);
    repeat (LAT + 3) step();
    check("post_rst_first_ack", 64'(ack_cyc.size()), 64'd1);
    if (ack_cyc.size() > 0) check("post_rst_tie_port", 64'(ack_port[0]), 64'd0);
    repeat (LAT + 4) step();
    req = 2'b00;
    repeat (LAT + 3) step();

    // Random traffic
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    req = 2'b00;
    repeat (LAT + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and access sequencer for the single shared memory of the multi-cycle processor. It shares the memory between port 0, the core's fetch/load/store path driven by IorD/MemWrite, and port 1, the program loader/debug port. Each accepted request becomes one fixed-latency memory access, and the block returns a one-cycle acknowledge with read data. Grants alternate round-robin so neither port can starve the other.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access cycles per transaction (legal range 1–15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req0, req1  in  1 each  access request from port 0 / port 1; level, held until ack
- we0, we1  in  1 each  1 = write, 0 = read; held stable with req
- addr0, addr1  in  AW each  access address; held stable with req
- wdata0, wdata1  in  DW each  write data; held stable with req
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata0, rdata1  out  DW each  read data; valid in the ack cycle and held until that port's next read completes
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid on the last access cycle
- grant  out  2  one-hot owner of the current transaction; 00 when idle
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - No request: stay in IDLE.
  - Exactly one of req0/req1 high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant: latch that port's we/addr/wdata into internal registers, set grant, set last_grant, load cnt = LAT−1, go to BUSY.
- BUSY
  - mem_en = 1; mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we.
  - cnt decrements each cycle.
  - When cnt == 0: if the access is a read, capture mem_rdata into rdata of the granted port. Then go to RESP.
- RESP
  - ack of the granted port = 1 for exactly this cycle.
  - Go to IDLE; grant clears on that transition.
- Port inputs are ignored outside IDLE. Changes to addr, we or wdata during BUSY do not affect the access in flight.
- A req dropped during BUSY is a protocol violation. The access still completes and ack still pulses.
- A write leaves that port's rdata unchanged. The other port's rdata is never touched by a transaction it does not own.
- last_grant resets to port 1, so port 0 wins the first tie.
- Reset (rst = 0, at any time, including mid-access):
  - State goes to IDLE immediately.
  - ack0/ack1, mem_en, mem_we, grant, busy = 0.
  - rdata0/rdata1, mem_addr, mem_wdata, cnt = 0.
  - last_grant = port 1.
  - An in-flight access is abandoned with no ack.

## Timing
- Request sampled high in IDLE at edge t:
  - BUSY for cycles t+1 through t+LAT.
  - RESP (ack) in cycle t+LAT+1.
  - IDLE again at t+LAT+2.
- Request-to-ack latency is LAT+1 cycles. Each transaction occupies LAT+2 cycles, including the mandatory IDLE cycle.
- The requester drops req (or presents a new request) on the edge that ends its ack cycle. IDLE then samples the updated inputs.
- With both ports continuously requesting, grants alternate 0,1,0,1…, one per LAT+2 cycles.
- mem_en/mem_we are registered outputs, high for exactly LAT consecutive cycles per transaction. They never glitch between transactions.
- With LAT = 1: BUSY lasts one cycle and mem_rdata is sampled at the end of that cycle.

## Test plan
- Reset then idle: hold rst = 0 for 3 cycles, then release with no requests → all outputs 0, grant = 00, busy = 0 for 10 cycles.
- Single read, LAT = 2: req0 = 1, we0 = 0, addr0 = 0x40, memory returns 0x12345678 → mem_en high for 2 cycles with mem_addr = 0x40, mem_we = 0; ack0 pulses 3 cycles after req is sampled; rdata0 = 0x12345678; ack1 stays 0.
- Single write on port 1: addr1 = 0x100, wdata1 = 0xDEADBEEF → mem_we = 1 for exactly 2 cycles with that address and data; ack1 pulses once; rdata1 is unchanged.
- Contention: req0 and req1 asserted together and held, each re-requesting after its ack → ack order is 0, 1, 0, 1; each ack spaced 4 cycles apart (LAT = 2).
- Input change mid-access: after grant, change addr0 from 0x40 to 0x80 during BUSY → mem_addr stays 0x40 for the whole access.
- Reset mid-access: drive rst = 0 in the second BUSY cycle → mem_en/grant/busy drop to 0 asynchronously; no ack; after release, the first tie is granted to port 0.
